// File: rtl/axil_pause_pkg.sv
// Shared definitions for the AXI4-Lite pause gate: FSM state encoding, response codes
// and the counter width helper.
package axil_pause_pkg;

    typedef logic [1:0] state_t;

    localparam state_t RUN    = 2'd0;
    localparam state_t DRAIN  = 2'd1;
    localparam state_t PAUSED = 2'd2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Bits needed to hold 0..max_trans inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_trans);
        return $clog2(max_trans + 1);
    endfunction

endpackage

// File: rtl/axil_pause_if.sv
// AXI4-Lite bundle. The master modport drives requests; the slave modport answers them.
interface axil_pause_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface

// File: rtl/axil_pause_cnt.sv
// Saturating up/down outstanding-transaction counter bounded to 0..MAX_TRANS.
module axil_pause_cnt
    import axil_pause_pkg::*;
#(
    parameter int unsigned MAX_TRANS = 7,
    parameter int unsigned CNT_W     = cnt_width(MAX_TRANS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRANS);

    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;

    assign full  = (count_q == MAX_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && dec) begin
            count_d = count_q;
        end else if (inc && !full) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axil_pause.sv
// AXI4-Lite pause gate: drains outstanding traffic on pause_req, then acknowledges.
// Bus widths follow the connected axil_pause_if; define AXIL_PAUSE_ASSERTIONS_EN for SVA checks.
module axil_pause
    import axil_pause_pkg::*;
#(
    parameter int unsigned MAX_TRANS = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pause_req,
    output logic         pause_ack,
    axil_pause_if.slave  slv,
    axil_pause_if.master mst
);

    localparam int unsigned CNT_W = cnt_width(MAX_TRANS);

    state_t           state_q, state_d;
    logic             pend_aw_q, pend_w_q, pend_ar_q;
    logic [CNT_W-1:0] aw_cnt, w_cnt, ar_cnt;
    logic             aw_full, w_full, ar_full;
    logic             allow_aw, allow_w, allow_ar;
    logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic             run, idle;

    // Payload and response channels pass straight through.
    assign mst.aw_addr = slv.aw_addr;
    assign mst.aw_prot = slv.aw_prot;
    assign mst.w_data  = slv.w_data;
    assign mst.w_strb  = slv.w_strb;
    assign mst.ar_addr = slv.ar_addr;
    assign mst.ar_prot = slv.ar_prot;
    assign slv.b_resp  = mst.b_resp;
    assign slv.b_valid = mst.b_valid;
    assign mst.b_ready = slv.b_ready;
    assign slv.r_data  = mst.r_data;
    assign slv.r_resp  = mst.r_resp;
    assign slv.r_valid = mst.r_valid;
    assign mst.r_ready = slv.r_ready;

    assign mst.aw_valid = slv.aw_valid & allow_aw;
    assign slv.aw_ready = mst.aw_ready & allow_aw;
    assign mst.w_valid  = slv.w_valid & allow_w;
    assign slv.w_ready  = mst.w_ready & allow_w;
    assign mst.ar_valid = slv.ar_valid & allow_ar;
    assign slv.ar_ready = mst.ar_ready & allow_ar;

    assign aw_hs = mst.aw_valid & mst.aw_ready;
    assign w_hs  = mst.w_valid & mst.w_ready;
    assign ar_hs = mst.ar_valid & mst.ar_ready;
    assign b_hs  = mst.b_valid & mst.b_ready;
    assign r_hs  = mst.r_valid & mst.r_ready;

    // While draining, only the half of a write that is still owed may pass, so every
    // accepted address eventually pairs with its data and a B can come back.
    assign run      = (state_q == RUN);
    assign allow_aw = pend_aw_q | (~aw_full & (run | (aw_cnt < w_cnt)));
    assign allow_w  = pend_w_q | (~w_full & (run | (w_cnt < aw_cnt)));
    assign allow_ar = pend_ar_q | (~ar_full & run);

    assign idle = (aw_cnt == '0) & (w_cnt == '0) & (ar_cnt == '0)
                & ~(pend_aw_q | pend_w_q | pend_ar_q);

    axil_pause_cnt #(.MAX_TRANS(MAX_TRANS), .CNT_W(CNT_W)) u_aw_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (aw_hs),
        .dec   (b_hs),
        .count (aw_cnt),
        .full  (aw_full)
    );

    axil_pause_cnt #(.MAX_TRANS(MAX_TRANS), .CNT_W(CNT_W)) u_w_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hs),
        .dec   (b_hs),
        .count (w_cnt),
        .full  (w_full)
    );

    axil_pause_cnt #(.MAX_TRANS(MAX_TRANS), .CNT_W(CNT_W)) u_ar_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ar_hs),
        .dec   (r_hs),
        .count (ar_cnt),
        .full  (ar_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (pause_req) state_d = DRAIN;
            DRAIN:   if (!pause_req) state_d = RUN;
                     else if (idle) state_d = PAUSED;
            PAUSED:  if (!pause_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // A pending flag marks a valid already presented downstream; it keeps the gate open
    // until that transfer completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pend_aw_q <= 1'b0;
            pend_w_q  <= 1'b0;
            pend_ar_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_aw_q <= mst.aw_valid & ~mst.aw_ready;
            pend_w_q  <= mst.w_valid & ~mst.w_ready;
            pend_ar_q <= mst.ar_valid & ~mst.ar_ready;
        end
    end

    assign pause_ack = (state_q == PAUSED);

`ifdef AXIL_PAUSE_ASSERTIONS_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRANS);

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (aw_cnt <= MAX_CNT) && (w_cnt <= MAX_CNT) && (ar_cnt <= MAX_CNT))
        else $error("axil_pause: counter out of range");
    a_b_underflow: assert property (@(posedge clk) disable iff (rst)
        b_hs |-> (aw_cnt != '0) && (w_cnt != '0))
        else $error("axil_pause: B handshake with no outstanding write");
    a_r_underflow: assert property (@(posedge clk) disable iff (rst)
        r_hs |-> (ar_cnt != '0))
        else $error("axil_pause: R handshake with no outstanding read");
    a_aw_stable: assert property (@(posedge clk) disable iff (rst) pend_aw_q |-> mst.aw_valid)
        else $error("axil_pause: mst aw_valid dropped without ready");
    a_w_stable: assert property (@(posedge clk) disable iff (rst) pend_w_q |-> mst.w_valid)
        else $error("axil_pause: mst w_valid dropped without ready");
    a_ar_stable: assert property (@(posedge clk) disable iff (rst) pend_ar_q |-> mst.ar_valid)
        else $error("axil_pause: mst ar_valid dropped without ready");
    a_paused_quiet: assert property (@(posedge clk) disable iff (rst)
        (state_q == PAUSED) |-> !(aw_hs || w_hs || ar_hs))
        else $error("axil_pause: request handshake while paused");
`endif

endmodule

// File: tb/tb_axil_pause.sv
// Directed self-checking bench for axil_pause with MAX_TRANS = 7.
module tb_axil_pause;
    import axil_pause_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic pause_req;
    logic pause_ack;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    axil_pause_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up ();
    axil_pause_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dn ();

    axil_pause #(.MAX_TRANS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .slv       (up),
        .mst       (dn)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        pause_req = 1'b0;
        up.aw_addr = '0; up.aw_prot = '0; up.aw_valid = 1'b0;
        up.w_data = '0; up.w_strb = '0; up.w_valid = 1'b0; up.b_ready = 1'b0;
        up.ar_addr = '0; up.ar_prot = '0; up.ar_valid = 1'b0; up.r_ready = 1'b0;
        dn.aw_ready = 1'b0; dn.w_ready = 1'b0; dn.b_resp = RESP_OKAY; dn.b_valid = 1'b0;
        dn.ar_ready = 1'b0; dn.r_data = '0; dn.r_resp = RESP_OKAY; dn.r_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk1("reset_ack", pause_ack, 1'b0);
        chk1("reset_aw_ready_no_sub", up.aw_ready, 1'b0);

        // Pass-through of payloads and responses.
        up.aw_addr = 32'h1234_5678; up.aw_prot = 3'b101;
        up.w_data = 32'hdead_beef; up.w_strb = 4'ha; up.ar_addr = 32'h0bad_f00d;
        dn.b_resp = 2'b10; dn.r_data = 32'hcafe_0001;
        up.b_ready = 1'b1; up.r_ready = 1'b1;
        #1;
        chk32("pt_aw_addr", dn.aw_addr, 32'h1234_5678);
        chk32("pt_aw_prot", 32'(dn.aw_prot), 32'h5);
        chk32("pt_w_data", dn.w_data, 32'hdead_beef);
        chk32("pt_w_strb", 32'(dn.w_strb), 32'ha);
        chk32("pt_ar_addr", dn.ar_addr, 32'h0bad_f00d);
        chk32("pt_b_resp", 32'(up.b_resp), 32'h2);
        chk32("pt_r_data", up.r_data, 32'hcafe_0001);
        chk1("pt_b_ready", dn.b_ready, 1'b1);
        chk1("pt_r_ready", dn.r_ready, 1'b1);
        dn.b_resp = RESP_OKAY;
        dn.aw_ready = 1'b1; dn.w_ready = 1'b1; dn.ar_ready = 1'b1;
        #1;
        chk1("run_aw_ready", up.aw_ready, 1'b1);
        chk1("run_w_ready", up.w_ready, 1'b1);
        chk1("run_ar_ready", up.ar_ready, 1'b1);

        // Idle pause: ack two cycles after request, drops one cycle after release.
        pause_req = 1'b1;
        step();
        chk1("idle_ack_c1", pause_ack, 1'b0);
        step();
        chk1("idle_ack_c2", pause_ack, 1'b1);
        chk1("paused_aw_ready", up.aw_ready, 1'b0);
        up.ar_valid = 1'b1; up.w_valid = 1'b1;
        #1;
        chk1("paused_ar_valid", dn.ar_valid, 1'b0);
        chk1("paused_w_valid", dn.w_valid, 1'b0);
        chk1("paused_ar_ready", up.ar_ready, 1'b0);
        up.ar_valid = 1'b0; up.w_valid = 1'b0;
        pause_req = 1'b0;
        step();
        chk1("resume_ack", pause_ack, 1'b0);
        chk1("resume_aw_ready", up.aw_ready, 1'b1);

        // Owed beat: address accepted before pause, its data still passes during drain.
        dn.w_ready = 1'b0; up.aw_valid = 1'b1;
        step();
        up.aw_valid = 1'b0; pause_req = 1'b1;
        step();
        up.aw_valid = 1'b1;
        #1;
        chk1("owed_aw_blocked", up.aw_ready, 1'b0);
        chk1("owed_aw_valid_blocked", dn.aw_valid, 1'b0);
        up.aw_valid = 1'b0; up.w_valid = 1'b1; dn.w_ready = 1'b1;
        #1;
        chk1("owed_w_fwd", dn.w_valid, 1'b1);
        chk1("owed_w_ready", up.w_ready, 1'b1);
        step();
        up.w_valid = 1'b0;
        chk1("owed_ack_wait", pause_ack, 1'b0);
        dn.b_valid = 1'b1;
        #1;
        chk1("owed_b_fwd", up.b_valid, 1'b1);
        step();
        dn.b_valid = 1'b0;
        chk1("owed_ack_pre", pause_ack, 1'b0);
        step();
        chk1("owed_ack", pause_ack, 1'b1);
        pause_req = 1'b0;
        step();
        chk1("owed_resume", pause_ack, 1'b0);

        // Limit: seven reads accepted, the eighth held until an R completes.
        up.ar_valid = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            chk1("lim_ready_open", up.ar_ready, 1'b1);
            step();
        end
        chk1("lim_8th_held", up.ar_ready, 1'b0);
        chk1("lim_8th_valid", dn.ar_valid, 1'b0);
        step();
        step();
        chk1("lim_still_held", up.ar_ready, 1'b0);
        dn.r_valid = 1'b1;
        #1;
        chk1("lim_r_fwd", up.r_valid, 1'b1);
        chk1("lim_held_during_r", up.ar_ready, 1'b0);
        step();
        dn.r_valid = 1'b0;
        #1;
        chk1("lim_reopen", up.ar_ready, 1'b1);
        step();
        chk1("lim_full_again", up.ar_ready, 1'b0);
        up.ar_valid = 1'b0; dn.r_valid = 1'b1;
        repeat (7) step();
        dn.r_valid = 1'b0;

        // Stability: a stalled downstream valid survives the pause request.
        dn.aw_ready = 1'b0; up.aw_valid = 1'b1;
        #1;
        chk1("stab_valid_up", dn.aw_valid, 1'b1);
        step();
        pause_req = 1'b1;
        step();
        chk1("stab_held_c1", dn.aw_valid, 1'b1);
        step();
        step();
        chk1("stab_held_c3", dn.aw_valid, 1'b1);
        chk1("stab_ack_wait", pause_ack, 1'b0);
        dn.aw_ready = 1'b1;
        #1;
        chk1("stab_aw_ready", up.aw_ready, 1'b1);
        step();
        up.aw_valid = 1'b0; up.w_valid = 1'b1;
        step();
        up.w_valid = 1'b0; dn.b_valid = 1'b1;
        step();
        dn.b_valid = 1'b0;
        chk1("stab_ack_pre", pause_ack, 1'b0);
        step();
        chk1("stab_ack", pause_ack, 1'b1);
        pause_req = 1'b0;
        step();
        chk1("stab_resume", pause_ack, 1'b0);

        // Drain: 3 writes and 2 reads outstanding, responses delayed 50 cycles.
        up.aw_valid = 1'b1; up.w_valid = 1'b1; up.ar_valid = 1'b1;
        step();
        step();
        up.ar_valid = 1'b0;
        step();
        up.aw_valid = 1'b0; up.w_valid = 1'b0;
        pause_req = 1'b1;
        step();
        up.aw_valid = 1'b1; up.ar_valid = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            chk1("drain_ack_low", pause_ack, 1'b0);
            chk1("drain_no_aw", dn.aw_valid, 1'b0);
            chk1("drain_no_ar", dn.ar_valid, 1'b0);
            step();
        end
        dn.b_valid = 1'b1; dn.r_valid = 1'b1;
        step();
        step();
        dn.r_valid = 1'b0;
        chk1("drain_ack_b1", pause_ack, 1'b0);
        step();
        dn.b_valid = 1'b0;
        chk1("drain_ack_last", pause_ack, 1'b0);
        step();
        chk1("drain_ack", pause_ack, 1'b1);
        chk1("drain_paused_aw", dn.aw_valid, 1'b0);
        up.aw_valid = 1'b0; up.ar_valid = 1'b0;
        pause_req = 1'b0;
        step();
        chk1("drain_resume", pause_ack, 1'b0);

        // Reset mid-transaction with pause_req held: bookkeeping cleared, request seen after.
        up.aw_valid = 1'b1;
        #1;
        step();
        up.aw_valid = 1'b0;
        rst = 1'b1; pause_req = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk1("rst_req_ack", pause_ack, 1'b0);
        step();
        chk1("rst_req_drain", pause_ack, 1'b0);
        step();
        chk1("rst_req_paused", pause_ack, 1'b1);
        pause_req = 1'b0;
        step();
        chk1("rst_req_resume", pause_ack, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
